pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential, jump, call/return and branch-on-flag
// control flow with a small LIFO return-address stack and sticky error flags.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_pc,
    input  logic [2:0]  branch,
    input  logic        push,
    input  logic        pop,
    input  logic        add_pc,
    input  logic        brfl_control,
    input  logic [3:0]  flags_in,
    input  logic [3:0]  flag_mask,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] reg_data,
    output logic [31:0] pc,
    output logic        halted,
    output logic [4:0]  stack_depth,
    output logic        stack_overflow,
    output logic        stack_underflow,
    output logic        protocol_err
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] BR_JR   = 3'b001;
    localparam logic [2:0] BR_CALL = 3'b010;
    localparam logic [2:0] BR_HALT = 3'b011;
    localparam logic [2:0] BR_JPC  = 3'b100;

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t state;

    logic [31:0]      stack_mem [STACK_DEPTH];
    logic             commit;
    logic [31:0]      pc_plus1;
    logic [31:0]      pc_rel;
    logic [31:0]      stack_top;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic             stack_full;
    logic             stack_empty;

    logic [31:0]      pc_next;
    logic [4:0]       depth_next;
    logic             push_en;
    logic             halt_set;
    logic             ovf_set;
    logic             unf_set;
    logic             perr_set;

    assign commit      = (state == RUN) && write_pc;
    assign pc_plus1    = pc + 32'd1;
    assign pc_rel      = pc_plus1 + {{16{imm16[15]}}, imm16};
    assign stack_full  = (stack_depth == 5'(STACK_DEPTH));
    assign stack_empty = (stack_depth == 5'd0);
    assign top_idx     = PTR_W'(stack_depth - 5'd1);
    assign wr_idx      = PTR_W'(stack_depth);
    assign stack_top   = stack_mem[top_idx];

    // Priority chain: halt, push/pop conflict, call, return, jr, jpc, brfl, sequential.
    always_comb begin
        pc_next    = pc_plus1;
        depth_next = stack_depth;
        push_en    = 1'b0;
        halt_set   = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        perr_set   = 1'b0;
        if (branch == BR_HALT) begin
            pc_next  = pc;
            halt_set = 1'b1;
        end else if (push && pop) begin
            perr_set = 1'b1;
        end else if ((branch == BR_CALL) || push) begin
            pc_next = {6'b0, jtarget};
            if (stack_full) begin
                ovf_set = 1'b1;
            end else begin
                push_en    = 1'b1;
                depth_next = stack_depth + 5'd1;
            end
        end else if (pop) begin
            if (stack_empty) begin
                unf_set = 1'b1;
            end else begin
                pc_next    = stack_top + {31'b0, add_pc};
                depth_next = stack_depth - 5'd1;
            end
        end else if (branch == BR_JR) begin
            pc_next = reg_data;
        end else if (branch == BR_JPC) begin
            pc_next = pc_rel;
        end else if (brfl_control && ((flags_in & flag_mask) != 4'b0000)) begin
            pc_next = pc_rel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            pc              <= RESET_PC;
            halted          <= 1'b0;
            stack_depth     <= 5'd0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            protocol_err    <= 1'b0;
        end else if (commit) begin
            pc              <= pc_next;
            stack_depth     <= depth_next;
            stack_overflow  <= stack_overflow  | ovf_set;
            stack_underflow <= stack_underflow | unf_set;
            protocol_err    <= protocol_err    | perr_set;
            if (halt_set) begin
                state  <= HALT;
                halted <= 1'b1;
            end
        end
    end

    // Entries above the pointer are don't-care, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (rst_n && commit && push_en) begin
            stack_mem[wr_idx] <= pc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for single-commit behaviour
// plus hand-written sequences for nesting, halt and reset corner cases.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        write_pc;
    logic [2:0]  branch;
    logic        push;
    logic        pop;
    logic        add_pc;
    logic        brfl_control;
    logic [3:0]  flags_in;
    logic [3:0]  flag_mask;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] reg_data;
    logic [31:0] pc;
    logic        halted;
    logic [4:0]  stack_depth;
    logic        stack_overflow;
    logic        stack_underflow;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .STACK_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .write_pc(write_pc), .branch(branch),
        .push(push), .pop(pop), .add_pc(add_pc), .brfl_control(brfl_control),
        .flags_in(flags_in), .flag_mask(flag_mask), .imm16(imm16),
        .jtarget(jtarget), .reg_data(reg_data), .pc(pc), .halted(halted),
        .stack_depth(stack_depth), .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  br;
        logic        ps;
        logic        pp;
        logic        add;
        logic        bf;
        logic [3:0]  fl;
        logic [3:0]  mk;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] rd;
        logic [31:0] e_pc;
        logic [4:0]  e_depth;
        logic [3:0]  e_stat;   // {halted, overflow, underflow, protocol_err}
    } vec_t;

    function automatic vec_t mkv(logic wr, logic [2:0] br, logic ps, logic pp,
                                 logic add, logic bf, logic [3:0] fl, logic [3:0] mk,
                                 logic [15:0] imm, logic [25:0] jt, logic [31:0] rd,
                                 logic [31:0] e_pc, logic [4:0] e_depth, logic [3:0] e_stat);
        vec_t v;
        v.wr = wr; v.br = br; v.ps = ps; v.pp = pp; v.add = add; v.bf = bf;
        v.fl = fl; v.mk = mk; v.imm = imm; v.jt = jt; v.rd = rd;
        v.e_pc = e_pc; v.e_depth = e_depth; v.e_stat = e_stat;
        return v;
    endfunction

    task automatic check_state(input string name, input logic [31:0] e_pc,
                               input logic [4:0] e_depth, input logic [3:0] e_stat);
        logic [3:0] stat;
        stat = {halted, stack_overflow, stack_underflow, protocol_err};
        checks++;
        if (pc !== e_pc || stack_depth !== e_depth || stat !== e_stat) begin
            errors++;
            $display("FAIL %s: pc=%h depth=%0d stat=%b, required pc=%h depth=%0d stat=%b",
                     name, pc, stack_depth, stat, e_pc, e_depth, e_stat);
        end else begin
            $display("ok   %s: pc=%h depth=%0d stat=%b", name, pc, stack_depth, stat);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        write_pc = v.wr; branch = v.br; push = v.ps; pop = v.pp; add_pc = v.add;
        brfl_control = v.bf; flags_in = v.fl; flag_mask = v.mk; imm16 = v.imm;
        jtarget = v.jt; reg_data = v.rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_pc = 1'b0; branch = 3'b000; push = 1'b0; pop = 1'b0; add_pc = 1'b0;
        brfl_control = 1'b0; flags_in = 4'b0; flag_mask = 4'b0; imm16 = 16'h0;
        jtarget = 26'h0; reg_data = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[23];
    vec_t v;
    logic [31:0] exp_pc;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        // Sequential, jr, call/return, brfl, error and wrap cases from reset.
        tbl[0]  = mkv(1, 3'b000, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'h0, 32'd1, 5'd0, 4'b0000);
        tbl[1]  = mkv(1, 3'b000, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'h0, 32'd2, 5'd0, 4'b0000);
        tbl[2]  = mkv(1, 3'b000, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'h0, 32'd3, 5'd0, 4'b0000);
        tbl[3]  = mkv(1, 3'b000, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'h0, 32'd4, 5'd0, 4'b0000);
        tbl[4]  = mkv(1, 3'b000, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'h0, 32'd5, 5'd0, 4'b0000);
        tbl[5]  = mkv(1, 3'b001, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'd10, 32'd10, 5'd0, 4'b0000);
        tbl[6]  = mkv(1, 3'b010, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'd100, 32'h0, 32'd100, 5'd1, 4'b0000);
        tbl[7]  = mkv(1, 3'b000, 0, 1, 1, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'h0, 32'd11, 5'd0, 4'b0000);
        tbl[8]  = mkv(1, 3'b001, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'd20, 32'd20, 5'd0, 4'b0000);
        tbl[9]  = mkv(1, 3'b000, 0, 0, 0, 1, 4'h2, 4'h2, 16'hFFFB, 26'h0, 32'h0, 32'd16, 5'd0, 4'b0000);
        tbl[10] = mkv(1, 3'b001, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'd20, 32'd20, 5'd0, 4'b0000);
        tbl[11] = mkv(1, 3'b000, 0, 0, 0, 1, 4'h2, 4'h4, 16'hFFFB, 26'h0, 32'h0, 32'd21, 5'd0, 4'b0000);
        tbl[12] = mkv(1, 3'b000, 0, 1, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'h0, 32'd22, 5'd0, 4'b0010);
        tbl[13] = mkv(1, 3'b000, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h3FF_FFFF, 32'h0, 32'h03FF_FFFF, 5'd1, 4'b0010);
        tbl[14] = mkv(1, 3'b000, 1, 1, 0, 0, 4'h0, 4'h0, 16'h0000, 26'd7, 32'h0, 32'h0400_0000, 5'd1, 4'b0011);
        tbl[15] = mkv(1, 3'b000, 0, 1, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'h0, 32'd22, 5'd0, 4'b0011);
        tbl[16] = mkv(1, 3'b100, 0, 0, 0, 0, 4'h0, 4'h0, 16'h7FFF, 26'h0, 32'h0, 32'd32790, 5'd0, 4'b0011);
        tbl[17] = mkv(1, 3'b100, 0, 0, 0, 0, 4'h0, 4'h0, 16'h8000, 26'h0, 32'h0, 32'd23, 5'd0, 4'b0011);
        tbl[18] = mkv(0, 3'b001, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'd99, 32'd23, 5'd0, 4'b0011);
        tbl[19] = mkv(1, 3'b001, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 4'b0011);
        tbl[20] = mkv(1, 3'b000, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'h0, 32'd0, 5'd0, 4'b0011);
        tbl[21] = mkv(1, 3'b101, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 26'h0, 32'h0, 32'd1, 5'd0, 4'b0011);
        tbl[22] = mkv(1, 3'b001, 0, 0, 0, 1, 4'h1, 4'h1, 16'd100, 26'h0, 32'd50, 32'd50, 5'd0, 4'b0011);

        // Reset is asynchronous: outputs settle before any clock edge.
        #2;
        check_state("reset_async", 32'd0, 5'd0, 4'b0000);
        do_reset();
        check_state("reset_state", 32'd0, 5'd0, 4'b0000);

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i]);
            check_state($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_depth, tbl[i].e_stat);
        end

        // Nine nested calls into an 8-entry stack, then eight LIFO returns.
        do_reset();
        apply(mkv(1, 3'b001, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0, 26'h0, 32'd200, 32'd200, 5'd0, 4'b0000));
        check_state("nest_start", 32'd200, 5'd0, 4'b0000);
        for (int i = 0; i < 9; i++) begin
            v = mkv(1, 3'b010, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0, 26'(1000 + i * 10), 32'h0,
                    32'(1000 + i * 10), (i < 8) ? 5'(i + 1) : 5'd8,
                    (i < 8) ? 4'b0000 : 4'b0100);
            apply(v);
            check_state($sformatf("call%0d", i), v.e_pc, v.e_depth, v.e_stat);
        end
        for (int i = 7; i >= 0; i--) begin
            exp_pc = (i == 0) ? 32'd200 : 32'(1000 + (i - 1) * 10);
            apply(mkv(1, 3'b000, 0, 1, 0, 0, 4'h0, 4'h0, 16'h0, 26'h0, 32'h0, 32'h0, 5'd0, 4'b0));
            check_state($sformatf("ret%0d", i), exp_pc, 5'(i), 4'b0100);
        end
        apply(mkv(1, 3'b000, 0, 1, 0, 0, 4'h0, 4'h0, 16'h0, 26'h0, 32'h0, 32'h0, 5'd0, 4'b0));
        check_state("ret_underflow", 32'd201, 5'd0, 4'b0110);

        // Halt at pc=7 freezes everything until reset.
        do_reset();
        for (int i = 0; i < 7; i++)
            apply(mkv(1, 3'b000, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0, 26'h0, 32'h0, 32'h0, 5'd0, 4'b0));
        check_state("pre_halt", 32'd7, 5'd0, 4'b0000);
        apply(mkv(1, 3'b011, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0, 26'd55, 32'h0, 32'h0, 5'd0, 4'b0));
        check_state("halt", 32'd7, 5'd0, 4'b1000);
        for (int i = 0; i < 10; i++) begin
            apply(mkv(1, 3'(i % 5), (i == 3), (i == 6), 0, 1, 4'hF, 4'hF, 16'd9, 26'd77,
                      32'd123, 32'h0, 5'd0, 4'b0));
        end
        check_state("halt_hold", 32'd7, 5'd0, 4'b1000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_state("halt_reset", 32'd0, 5'd0, 4'b0000);
        rst_n = 1'b1;
        idle_inputs();

        // Reset asserted just before a call commit's edge aborts it;
        // the first edge after release accepts a commit.
        apply(mkv(1, 3'b010, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0, 26'd300, 32'h0, 32'h0, 5'd0, 4'b0));
        check_state("call_pre_abort", 32'd300, 5'd1, 4'b0000);
        @(negedge clk);
        write_pc = 1'b1; branch = 3'b010; jtarget = 26'd400;
        #3 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_state("abort_commit", 32'd0, 5'd0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        branch = 3'b000; write_pc = 1'b1;
        @(posedge clk);
        #1;
        check_state("first_commit", 32'd1, 5'd0, 4'b0000);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
